fetch_redirect_unit: RTL and testbench

- Instruction-fetch front end that owns the architectural PC.
- Issues single-outstanding requests to instruction memory and presents fetched instructions to decode through a valid/ready handshake.
- Consumes the execute-stage branch decision and target, redirects the PC, and squashes any stale in-flight or held instruction.
- This is the consumer side of the branch-decision interface: execute decides and this block acts on that decision.

---
 rtl/fetch_redirect_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - instruction fetch front end with execute-driven PC redirect
//
// Owns the architectural PC, keeps a single request outstanding to instruction
// memory, and holds each fetched word for decode under a valid/ready handshake.
// A taken branch from execute (ex_valid & ex_takebranch) reloads the PC and
// squashes any stale in-flight or held instruction.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a misaligned redirect target traps (if_misalign=1, TRAP state)
//   undefined - target bits [1:0] are forced to 2'b00, if_misalign tied to 0
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req, imem_addr           registered fetch request, address (= pc)
//   imem_ack, imem_rdata          one-cycle completion pulse and fetched word
//   if_valid, if_instr, if_pc     held instruction presented to decode
//   if_ready                      decode accepts the held instruction
//   ex_valid, ex_takebranch       execute-stage branch decision
//   ex_target                     redirect target
//   if_misalign                   misaligned-target trap flag
module fetch_redirect_unit #(
    parameter int                   DATA_BITS = 32,
    parameter logic [DATA_BITS-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [DATA_BITS-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [DATA_BITS-1:0] imem_rdata,
    output logic                 if_valid,
    output logic [DATA_BITS-1:0] if_instr,
    output logic [DATA_BITS-1:0] if_pc,
    input  logic                 if_ready,
    input  logic                 ex_valid,
    input  logic                 ex_takebranch,
    input  logic [DATA_BITS-1:0] ex_target,
    output logic                 if_misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {BOOT, FETCH, HOLD, DROP, TRAP} state_t;
`else
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_t;
`endif

    state_t               state, state_n;
    logic [DATA_BITS-1:0] pc, pc_n;
    logic [DATA_BITS-1:0] instr_n, ifpc_n;
    logic                 valid_n, req_n, mis_n;
    logic                 redirect;
    logic [DATA_BITS-1:0] target;

    localparam logic [DATA_BITS-1:0] LOW_BITS = {{(DATA_BITS-2){1'b0}}, 2'b11};

    assign redirect  = ex_valid & ex_takebranch;
    assign imem_addr = pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    // Tracks a request issued before entering TRAP whose ack has not yet
    // arrived, so leaving TRAP cannot mistake that ack for the new fetch.
    logic pend, pend_n;

    assign misaligned = redirect && ((ex_target & LOW_BITS) != '0);
    assign target     = ex_target;
`else
    assign target     = ex_target & ~LOW_BITS;
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = if_valid;
        instr_n = if_instr;
        ifpc_n  = if_pc;
        mis_n   = if_misalign;
`ifdef FETCH_MISALIGN_TRAP_EN
        pend_n  = pend;
`endif

        case (state)
            BOOT: begin
                state_n = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    // Same-cycle ack is discarded and refetch starts next cycle;
                    // otherwise the old request is still in flight.
                    pc_n    = target;
                    state_n = imem_ack ? FETCH : DROP;
                end else if (imem_ack) begin
                    instr_n = imem_rdata;
                    ifpc_n  = pc;
                    valid_n = 1'b1;
                    state_n = HOLD;
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_n = target;
                end
                if (imem_ack) begin
                    state_n = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_n = 1'b0;
                    pc_n    = target;
                    state_n = FETCH;
                end else if (if_ready) begin
                    valid_n = 1'b0;
                    pc_n    = pc + DATA_BITS'(4);
                    state_n = FETCH;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            TRAP: begin
                if (imem_ack) begin
                    pend_n = 1'b0;
                end
                if (redirect) begin
                    pc_n    = target;
                    mis_n   = 1'b0;
                    // A still-pending stale ack must be absorbed before refetching.
                    state_n = (pend && !imem_ack) ? DROP : FETCH;
                end
            end
`endif
            default: begin
                state_n = BOOT;
            end
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        if (misaligned) begin
            if (state == FETCH || state == DROP) begin
                pend_n = !imem_ack;
            end
            pc_n    = ex_target;
            mis_n   = 1'b1;
            valid_n = 1'b0;
            state_n = TRAP;
        end
`endif

        req_n = (state_n == FETCH) || (state_n == DROP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_misalign <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            imem_req    <= req_n;
            if_valid    <= valid_n;
            if_instr    <= instr_n;
            if_pc       <= ifpc_n;
            if_misalign <= mis_n;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            pend <= pend_n;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - cycle-level directed vector bench for fetch_redirect_unit
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        ex_valid;
    logic        ex_takebranch;
    logic [31:0] ex_target;
    logic        if_misalign;

    fetch_redirect_unit #(.DATA_BITS(32), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready),
        .ex_valid(ex_valid), .ex_takebranch(ex_takebranch), .ex_target(ex_target),
        .if_misalign(if_misalign)
    );

    always #5 clk = ~clk;

    // Inputs drive the cycle; expectations are the outputs seen during that cycle.
    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        exv;
        logic        tk;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t tbl[0:39];
    int   n_vec;
    int   n_applied = 0;
    int   n_bad     = 0;

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic rdy,
                                input logic exv, input logic tk, input logic [31:0] tgt,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_instr,
                                input logic [31:0] e_pc, input logic e_mis);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.exv = exv; v.tk = tk; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic req, input logic [31:0] addr,
                       input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                       input logic mis);
        n_applied++;
        if (imem_req !== req || imem_addr !== addr || if_valid !== valid ||
            if_instr !== instr || if_pc !== pc || if_misalign !== mis) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc=%h mis=%b, want req=%b addr=%h valid=%b instr=%h pc=%h mis=%b",
                     name, imem_req, imem_addr, if_valid, if_instr, if_pc, if_misalign,
                     req, addr, valid, instr, pc, mis);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                         input logic exv, input logic tk, input logic [31:0] tgt);
        imem_ack = ack; imem_rdata = rdata; if_ready = rdy;
        ex_valid = exv; ex_takebranch = tk; ex_target = tgt;
    endtask

    localparam logic [31:0] Z = 32'h0;

    initial begin
        // Sequential fetch 0x100/0x104/0x108 with 1-cycle acks
        tbl[0]  = mk(0, Z, 0, 0, 0, Z,            0, 32'h100, 0, Z, Z, 0);
        tbl[1]  = mk(1, 32'hAAAA_0100, 1, 0, 0, Z, 1, 32'h100, 0, Z, Z, 0);
        tbl[2]  = mk(0, Z, 1, 0, 0, Z,            0, 32'h100, 1, 32'hAAAA_0100, 32'h100, 0);
        tbl[3]  = mk(1, 32'hAAAA_0104, 1, 0, 0, Z, 1, 32'h104, 0, 32'hAAAA_0100, 32'h100, 0);
        tbl[4]  = mk(0, Z, 1, 0, 0, Z,            0, 32'h104, 1, 32'hAAAA_0104, 32'h104, 0);
        tbl[5]  = mk(1, 32'hAAAA_0108, 1, 0, 0, Z, 1, 32'h108, 0, 32'hAAAA_0104, 32'h104, 0);
        // Hold with if_ready low for five cycles
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(0, Z, 0, 0, 0, Z,         0, 32'h108, 1, 32'hAAAA_0108, 32'h108, 0);
        tbl[11] = mk(0, Z, 1, 0, 0, Z,            0, 32'h108, 1, 32'hAAAA_0108, 32'h108, 0);
        // Redirect to 0x200 in FETCH with ack delayed: DROP absorbs stale word
        tbl[12] = mk(0, Z, 0, 1, 1, 32'h200,      1, 32'h10C, 0, 32'hAAAA_0108, 32'h108, 0);
        tbl[13] = mk(0, Z, 0, 0, 0, Z,            1, 32'h200, 0, 32'hAAAA_0108, 32'h108, 0);
        tbl[14] = mk(0, Z, 0, 0, 0, Z,            1, 32'h200, 0, 32'hAAAA_0108, 32'h108, 0);
        tbl[15] = mk(1, 32'hDEAD_010C, 0, 0, 0, Z, 1, 32'h200, 0, 32'hAAAA_0108, 32'h108, 0);
        tbl[16] = mk(1, 32'hAAAA_0200, 0, 0, 0, Z, 1, 32'h200, 0, 32'hAAAA_0108, 32'h108, 0);
        tbl[17] = mk(0, Z, 1, 0, 0, Z,            0, 32'h200, 1, 32'hAAAA_0200, 32'h200, 0);
        // Redirect to 0x40 coincident with ack
        tbl[18] = mk(1, 32'hDEAD_0204, 0, 1, 1, 32'h40, 1, 32'h204, 0, 32'hAAAA_0200, 32'h200, 0);
        tbl[19] = mk(1, 32'hAAAA_0040, 0, 0, 0, Z, 1, 32'h040, 0, 32'hAAAA_0200, 32'h200, 0);
        // Redirect to 0x80 together with if_ready in HOLD
        tbl[20] = mk(0, Z, 1, 1, 1, 32'h80,       0, 32'h040, 1, 32'hAAAA_0040, 32'h040, 0);
        // Not-taken and invalid branch decisions leave pc alone
        tbl[21] = mk(1, 32'hAAAA_0080, 0, 1, 0, 32'h999, 1, 32'h080, 0, 32'hAAAA_0040, 32'h040, 0);
        tbl[22] = mk(0, Z, 0, 0, 1, 32'h500,      0, 32'h080, 1, 32'hAAAA_0080, 32'h080, 0);
        // Misaligned redirect target 0x202
        tbl[23] = mk(0, Z, 0, 1, 1, 32'h202,      0, 32'h080, 1, 32'hAAAA_0080, 32'h080, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        tbl[24] = mk(0, Z, 0, 0, 0, Z,            0, 32'h202, 0, 32'hAAAA_0080, 32'h080, 1);
        tbl[25] = mk(0, Z, 0, 1, 1, 32'h300,      0, 32'h202, 0, 32'hAAAA_0080, 32'h080, 1);
        tbl[26] = mk(1, 32'hAAAA_0300, 0, 0, 0, Z, 1, 32'h300, 0, 32'hAAAA_0080, 32'h080, 0);
        tbl[27] = mk(0, Z, 0, 0, 0, Z,            0, 32'h300, 1, 32'hAAAA_0300, 32'h300, 0);
        n_vec = 28;
`else
        tbl[24] = mk(1, 32'hAAAA_0200, 0, 0, 0, Z, 1, 32'h200, 0, 32'hAAAA_0080, 32'h080, 0);
        // PC wrap from 0xFFFF_FFFC to 0
        tbl[25] = mk(0, Z, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h200, 1, 32'hAAAA_0200, 32'h200, 0);
        tbl[26] = mk(1, 32'hAAAA_FFFC, 0, 0, 0, Z, 1, 32'hFFFF_FFFC, 0, 32'hAAAA_0200, 32'h200, 0);
        tbl[27] = mk(0, Z, 1, 0, 0, Z,            0, 32'hFFFF_FFFC, 1, 32'hAAAA_FFFC, 32'hFFFF_FFFC, 0);
        // Redirect with no ack, then a second redirect while in DROP
        tbl[28] = mk(0, Z, 0, 1, 1, 32'h100,      1, 32'h000, 0, 32'hAAAA_FFFC, 32'hFFFF_FFFC, 0);
        tbl[29] = mk(0, Z, 0, 1, 1, 32'h300,      1, 32'h100, 0, 32'hAAAA_FFFC, 32'hFFFF_FFFC, 0);
        tbl[30] = mk(1, 32'hDEAD_0000, 0, 0, 0, Z, 1, 32'h300, 0, 32'hAAAA_FFFC, 32'hFFFF_FFFC, 0);
        tbl[31] = mk(1, 32'hAAAA_0300, 0, 0, 0, Z, 1, 32'h300, 0, 32'hAAAA_FFFC, 32'hFFFF_FFFC, 0);
        tbl[32] = mk(0, Z, 0, 0, 0, Z,            0, 32'h300, 1, 32'hAAAA_0300, 32'h300, 0);
        n_vec = 33;
`endif

        drive(0, Z, 0, 0, 0, Z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 32'h100, 0, Z, Z, 0);
        rst = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].exv, tbl[i].tk, tbl[i].tgt);
            @(negedge clk);
            chk($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_mis);
            @(posedge clk);
            #1;
        end

        // Accept the held word, then redirect with no ack to enter DROP
        drive(0, Z, 1, 0, 0, Z);
        @(posedge clk); #1;
        drive(0, Z, 0, 1, 1, 32'h400);
        @(posedge clk); #1;
        drive(0, Z, 0, 0, 0, Z);
        @(negedge clk);
        chk("drop_before_rst", 1, 32'h400, 0, 32'hAAAA_0300, 32'h300, 0);
        // Asynchronous reset mid-DROP takes effect without a clock edge
        #1 rst = 1'b1;
        #1;
        chk("async_rst", 0, 32'h100, 0, Z, Z, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // A late ack during BOOT must be ignored
        drive(1, 32'hDEAD_BEEF, 1, 0, 0, Z);
        @(negedge clk);
        chk("boot_late_ack", 0, 32'h100, 0, Z, Z, 0);
        @(posedge clk); #1;
        drive(0, Z, 0, 0, 0, Z);
        @(negedge clk);
        chk("fetch_after_boot", 1, 32'h100, 0, Z, Z, 0);
        @(posedge clk); #1;
        drive(1, 32'hAAAA_0100, 0, 0, 0, Z);
        @(posedge clk); #1;
        drive(0, Z, 0, 0, 0, Z);
        @(negedge clk);
        chk("hold_after_reset", 0, 32'h100, 1, 32'hAAAA_0100, 32'h100, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
        $finish;
    end

endmodule
